axis_elastic_buffer: RTL and testbench

Parametrised successor to the two-entry skid buffer: a DEPTH-entry elastic buffer on a valid/ready stream with registered outputs, end-of-packet sideband, occupancy reporting, almost-full flag and synchronous flush. It sits between AXI4-Stream-style producers and consumers wherever a stage must absorb more than one beat of backpressure or cut the timing path on both valid/data and ready. Data order is strictly preserved; no beat is dropped or duplicated.

---
 rtl/axis_elastic_buffer.sv | 80 ++++++++
 tb/tb_axis_elastic_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_elastic_buffer.sv
// DEPTH-entry elastic buffer on a valid/ready stream. Ready, valid and the head
// beat are all registered so neither direction has a combinational path through.
module axis_elastic_buffer #(
    parameter int DATA_SIZE   = 8,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = DEPTH - 1
) (
    input  logic                         clk_i,
    input  logic                         rst_clk_i,
    input  logic [DATA_SIZE-1:0]         data_i,
    input  logic                         data_last_i,
    input  logic                         data_valid_i,
    output logic                         data_ready_o,
    output logic [DATA_SIZE-1:0]         data_o,
    output logic                         data_last_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         almost_full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_SIZE:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr, rd_nxt;
    logic               push, pop;
    logic [LW-1:0]      next_level;
    logic [DATA_SIZE:0] head_nxt;

    always_comb begin
        push       = data_valid_i & data_ready_o;
        pop        = data_valid_o & data_ready_i;
        next_level = level_o + LW'(push) - LW'(pop);
        rd_nxt     = rd_ptr + PW'(pop);
        // An incoming beat that lands in an otherwise empty buffer becomes the head directly.
        if (push && (level_o - LW'(pop)) == '0)
            head_nxt = {data_last_i, data_i};
        else
            head_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_clk_i)
            mem[wr_ptr] <= {data_last_i, data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_clk_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
            data_ready_o  <= 1'b0;
            data_valid_o  <= 1'b0;
            almost_full_o <= 1'b0;
            data_o        <= '0;
            data_last_o   <= 1'b0;
        end else if (flush_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
            data_ready_o  <= 1'b1;
            data_valid_o  <= 1'b0;
            almost_full_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr        <= rd_nxt;
            level_o       <= next_level;
            data_ready_o  <= next_level < LW'(DEPTH);
            data_valid_o  <= next_level != '0;
            almost_full_o <= next_level >= LW'(ALMOST_FULL);
            // Head only reloads while something is stored; when stalled rd_nxt == rd_ptr keeps it stable.
            if (next_level != '0)
                {data_last_o, data_o} <= head_nxt;
        end
    end

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Scoreboard bench for axis_elastic_buffer (DEPTH 4): beats are queued as they
// are accepted and compared when the buffer hands them out.
module tb_axis_elastic_buffer;

    logic       clk_i = 1'b0;
    logic       rst_clk_i = 1'b1;
    logic [7:0] data_i = '0;
    logic       data_last_i = 1'b0;
    logic       data_valid_i = 1'b0;
    logic       data_ready_o;
    logic [7:0] data_o;
    logic       data_last_o;
    logic       data_valid_o;
    logic       data_ready_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [2:0] level_o;
    logic       almost_full_o;

    axis_elastic_buffer #(.DATA_SIZE(8), .DEPTH(4), .ALMOST_FULL(3)) dut (
        .clk_i(clk_i), .rst_clk_i(rst_clk_i),
        .data_i(data_i), .data_last_i(data_last_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o),
        .data_o(data_o), .data_last_o(data_last_o), .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i), .flush_i(flush_i),
        .level_o(level_o), .almost_full_o(almost_full_o)
    );

    always #5 clk_i = ~clk_i;

    logic [8:0] sb[$];
    int vecs = 0, errs = 0, mlevel = 0, npops = 0;

    // One clock: account handshakes seen before the edge, then check state after it.
    task automatic tick();
        logic push, pop, r, stall;
        logic [8:0] held, exp;
        push  = (data_valid_i === 1'b1) && (data_ready_o === 1'b1);
        pop   = (data_valid_o === 1'b1) && (data_ready_i === 1'b1);
        r     = rst_clk_i;
        stall = !r && !flush_i && (data_valid_o === 1'b1) && (data_ready_i !== 1'b1);
        held  = {data_last_o, data_o};
        if (r || flush_i) begin
            sb.delete();
            mlevel = 0;
        end else begin
            if (pop) begin
                vecs++;
                npops++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL pop_unexpected: got %h, none expected", held);
                end else begin
                    exp = sb.pop_front();
                    if (held !== exp) begin
                        errs++;
                        $display("FAIL beat_out: got %h, expected %h", held, exp);
                    end
                end
            end
            if (push) sb.push_back({data_last_i, data_i});
            mlevel = mlevel + int'(push) - int'(pop);
        end
        @(posedge clk_i);
        #1;
        vecs++;
        if (level_o !== 3'(mlevel) || data_valid_o !== (mlevel != 0) ||
            data_ready_o !== (!r && mlevel < 4) || almost_full_o !== (mlevel >= 3)) begin
            errs++;
            $display("FAIL state: got lvl=%0d v=%b r=%b af=%b, expected lvl=%0d v=%b r=%b af=%b",
                     level_o, data_valid_o, data_ready_o, almost_full_o,
                     mlevel, mlevel != 0, !r && mlevel < 4, mlevel >= 3);
        end
        if (stall) begin
            vecs++;
            if ({data_last_o, data_o} !== held) begin
                errs++;
                $display("FAIL stable_head: got %h, expected %h", {data_last_o, data_o}, held);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit ok = 0;
        data_i = d; data_last_i = l; data_valid_i = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            ok = (data_ready_o === 1'b1);
            tick();
        end
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL send_timeout: beat %h not accepted, expected acceptance", d);
        end
    endtask

    task automatic drain();
        data_valid_i = 1'b0;
        data_ready_i = 1'b1;
        for (int k = 0; k < 64 && sb.size() != 0; k++) tick();
        tick();
        vecs++;
        if (sb.size() != 0 || data_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL drain: got %0d pending v=%b, expected 0 pending v=0", sb.size(), data_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_clk_i = 1'b1; data_valid_i = 1'b1; data_i = 8'h11; data_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++;
            if ({data_valid_o, data_ready_o, data_o, data_last_o, level_o, almost_full_o} !== '0) begin
                errs++;
                $display("FAIL reset_outputs: got v=%b r=%b d=%h l=%b lvl=%0d, expected all 0",
                         data_valid_o, data_ready_o, data_o, data_last_o, level_o);
            end
        end
        data_valid_i = 1'b0;
        rst_clk_i = 1'b0;
        tick();
        vecs++;
        if (data_ready_o !== 1'b1 || level_o !== 3'd0) begin
            errs++;
            $display("FAIL reset_release: got r=%b lvl=%0d, expected r=1 lvl=0", data_ready_o, level_o);
        end
    endtask

    task automatic test_streaming();
        int p0 = npops;
        data_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), i == 255);
            vecs++;
            if (level_o > 3'd1 || data_valid_o !== 1'b1 || (i == 0 && data_o !== 8'h00)) begin
                errs++;
                $display("FAIL stream_%0d: got lvl=%0d v=%b d=%h, expected lvl<=1 v=1", i, level_o, data_valid_o, data_o);
            end
        end
        drain();
        vecs++;
        if (npops - p0 != 256) begin
            errs++;
            $display("FAIL stream_count: got %0d, expected 256", npops - p0);
        end
    endtask

    task automatic test_fill_drain();
        data_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 1'b0);
            vecs++;
            if (almost_full_o !== (i >= 2) || data_ready_o !== (i < 3)) begin
                errs++;
                $display("FAIL fill_%0d: got af=%b r=%b, expected af=%b r=%b", i, almost_full_o, data_ready_o, i >= 2, i < 3);
            end
        end
        data_i = 8'hA4; data_valid_i = 1'b1;
        tick();
        data_ready_i = 1'b1;
        tick();
        vecs++;
        if (data_ready_o !== 1'b1 || level_o !== 3'd3) begin
            errs++;
            $display("FAIL ready_rerise: got r=%b lvl=%0d, expected r=1 lvl=3", data_ready_o, level_o);
        end
        send(8'hA4, 1'b0);
        send(8'hA5, 1'b1);
        drain();
    endtask

    task automatic test_simul();
        data_ready_i = 1'b0;
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        data_ready_i = 1'b1;
        for (int i = 2; i < 8; i++) begin
            send(8'hA0 + 8'(i), i == 3);
            vecs++;
            if (level_o !== 3'd2) begin
                errs++;
                $display("FAIL simul_level_%0d: got %0d, expected 2", i, level_o);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        int p0;
        data_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b0);
        flush_i = 1'b1; data_valid_i = 1'b1; data_i = 8'hEE; data_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        vecs++;
        if (level_o !== 3'd0 || data_valid_o !== 1'b0 || data_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL flush: got lvl=%0d v=%b r=%b, expected lvl=0 v=0 r=1", level_o, data_valid_o, data_ready_o);
        end
        p0 = npops;
        send(8'h55, 1'b1);
        drain();
        vecs++;
        if (npops - p0 != 1) begin
            errs++;
            $display("FAIL flush_after: got %0d beats, expected 1", npops - p0);
        end
    endtask

    task automatic test_reset_mid();
        data_ready_i = 1'b0;
        send(8'hD0, 1'b0);
        send(8'hD1, 1'b0);
        rst_clk_i = 1'b1; flush_i = 1'b1; data_valid_i = 1'b1;
        tick();
        rst_clk_i = 1'b0; flush_i = 1'b0; data_valid_i = 1'b0;
        vecs++;
        if (level_o !== 3'd0 || data_o !== 8'h00 || data_ready_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid: got lvl=%0d d=%h r=%b, expected lvl=0 d=00 r=0", level_o, data_o, data_ready_o);
        end
        tick();
    endtask

    task automatic test_random();
        int sent = 0, p0 = npops;
        for (int c = 0; c < 20000 && sent < 1024; c++) begin
            if (data_valid_i !== 1'b1) begin
                data_valid_i = 1'($urandom_range(0, 1));
                data_i = 8'($urandom);
                data_last_i = 1'($urandom_range(0, 1));
            end
            data_ready_i = 1'($urandom_range(0, 1));
            if (data_valid_i && data_ready_o) sent++;
            tick();
            if (sent > 0 && data_ready_o === 1'b1 && data_valid_i === 1'b1 && ($urandom_range(0, 1) == 1))
                ;
            if (data_valid_i === 1'b1 && sb.size() > 0 && {data_last_i, data_i} === sb[$] && mlevel >= 0)
                data_valid_i = 1'($urandom_range(0, 1));
        end
        drain();
        vecs++;
        if (sent != 1024 || npops - p0 != 1024) begin
            errs++;
            $display("FAIL random_count: got sent=%0d out=%0d, expected 1024/1024", sent, npops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_drain();
        test_simul();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
